// File: rtl/output_dwell_pkg.sv
// Shared types and helpers for the output dwell / break-before-make driver.
//   state_t   : controller state (IDLE, GAP, HOLD), 2-bit encoding
//   OFF       : the all-lines-low drive value
//   needs_gap : true when moving between two different non-zero drives
package output_dwell_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] OFF = 2'b00;

  function automatic logic needs_gap(input logic [1:0] cur, input logic [1:0] nxt);
    return (cur != OFF) && (nxt != OFF) && (cur != nxt);
  endfunction

endpackage

// File: rtl/output_dwell_2bits_dwell_counter.sv
// Up-counter shared by the GAP and HOLD phases.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force count to zero (has priority over enable)
//   enable    : advance count by one
//   terminal  : compare value for the current phase
//   done      : enabled and count has reached terminal
// The counter never wraps because the controller clears it on done.
module dwell_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign done = enable && (count == terminal);

endmodule

// File: rtl/output_dwell_2bits.sv
// Drives two external switch lines from clean internal requests.
// Every change of drive_out is followed by a minimum dwell, and a direct
// change between two different non-zero values goes through a GAP where
// both lines are low.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : request present
//   req_data   : requested line state (sampled only on accept)
//   req_ready  : request can be accepted this cycle
//   abort      : synchronous force-off (dwelled like any other change)
//   drive_out  : registered line drive
//   busy       : controller not in IDLE
//
// state | meaning
// IDLE  | drive_out stable, dwell satisfied, requests accepted
// GAP   | lines held at OFF before applying the pending non-zero value
// HOLD  | minimum dwell after the last drive_out change
module output_dwell_2bits
  import output_dwell_pkg::*;
#(
  parameter int DWELL_CYCLES = 5000,
  parameter int GAP_CYCLES   = 50,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_data,
  output logic       req_ready,
  input  logic       abort,
  output logic [1:0] drive_out,
  output logic       busy
);

  state_t           state;
  logic [1:0]       pending;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_done;
  logic [CNT_W-1:0] terminal;

  assign req_ready = (state == IDLE) && !abort;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);

  // GAP and HOLD share one counter; the terminal follows the phase.
  assign terminal = (state == GAP) ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(DWELL_CYCLES - 1);

  // Clearing in IDLE guarantees every phase starts counting from zero,
  // and holding abort keeps the count pinned at zero.
  assign cnt_en    = (state != IDLE);
  assign cnt_clear = abort || (state == IDLE) || cnt_done;

  dwell_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (terminal),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drive_out <= OFF;
      pending   <= OFF;
    end else if (abort) begin
      pending <= OFF;
      // Already off and settled: nothing changes, so no dwell is needed.
      if (!((state == IDLE) && (drive_out == OFF))) begin
        drive_out <= OFF;
        state     <= HOLD;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept && (req_data != drive_out)) begin
            if (needs_gap(drive_out, req_data)) begin
              drive_out <= OFF;
              pending   <= req_data;
              state     <= GAP;
            end else begin
              drive_out <= req_data;
              state     <= HOLD;
            end
          end
        end
        GAP: begin
          if (cnt_done) begin
            drive_out <= pending;
            pending   <= OFF;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          drive_out <= OFF;
          pending   <= OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_dwell_2bits.sv
module tb_output_dwell_2bits;

  localparam int D = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_data = 2'b00;
  logic       abort = 1'b0;
  logic       req_ready;
  logic [1:0] drive_out;
  logic       busy;

  int checks = 0;
  int failures = 0;

  output_dwell_2bits #(
    .DWELL_CYCLES(D),
    .GAP_CYCLES  (G),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .abort     (abort),
    .drive_out (drive_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Timestamp model: k counts clock edges; the block is idle once
  // k reaches idle_edge, and a pending value lands at edge pend_edge.
  int         k = 0;
  int         idle_edge = 0;
  int         pend_edge = -1;
  logic [1:0] m_drive = 2'b00;
  logic [1:0] m_pend = 2'b00;
  bit         m_started = 0;

  always @(posedge clk) begin
    bit idle;
    idle = (k >= idle_edge);
    if (rst) begin
      m_drive   = 2'b00;
      pend_edge = -1;
      idle_edge = k + 1;
    end else if (abort) begin
      if (!(idle && m_drive == 2'b00)) begin
        m_drive   = 2'b00;
        pend_edge = -1;
        idle_edge = k + 1 + D;
      end
    end else if (idle && req_valid) begin
      if (req_data == m_drive) begin
        // same value: nothing happens
      end else if (m_drive != 2'b00 && req_data != 2'b00) begin
        m_drive   = 2'b00;
        m_pend    = req_data;
        pend_edge = k + 1 + G;
        idle_edge = k + 1 + G + D;
      end else begin
        m_drive   = req_data;
        idle_edge = k + 1 + D;
      end
    end else if (pend_edge == k + 1) begin
      m_drive   = m_pend;
      pend_edge = -1;
    end
    k = k + 1;
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model drive_out", int'(drive_out), int'(m_drive));
      chk("model busy", int'(busy), int'(k < idle_edge));
      chk("model req_ready", int'(req_ready), int'(!(k < idle_edge) && !abort));
    end
  end

  bit watch11 = 0, saw11 = 0, watch10 = 0, saw10 = 0;
  always @(negedge clk) begin
    if (watch11 && drive_out == 2'b11) saw11 = 1;
    if (watch10 && drive_out == 2'b10) saw10 = 1;
  end

  task automatic wait_ready(input string name, output int n);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      failures++;
      checks++;
      $display("FAIL %s: req_ready timeout got %0d cycles expected below 50", name, n);
    end
  endtask

  task automatic request(input logic [1:0] d);
    req_valid = 1'b1;
    req_data  = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic count_off(input string name, output int n);
    n = 0;
    @(negedge clk);
    while (drive_out == 2'b00 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      failures++;
      checks++;
      $display("FAIL %s: drive_out stuck at 0 got %0d cycles expected below 50", name, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset then idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset drive_out", int'(drive_out), 0);
    chk("reset req_ready", int'(req_ready), 1);
    chk("reset busy", int'(busy), 0);

    // simple set, then a 00 request held valid through the dwell
    req_valid = 1'b1;
    req_data  = 2'b01;
    @(posedge clk);
    #1 req_data = 2'b00;
    wait_ready("set dwell", n);
    chk("set ready low cycles", n, 4);
    chk("set drive_out", int'(drive_out), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_ready("clear dwell", n);
    chk("clear ready low cycles", n, 4);
    chk("clear drive_out", int'(drive_out), 0);

    // break-before-make 01 -> 10
    request(2'b01);
    wait_ready("to 01", n);
    watch11 = 1;
    request(2'b10);
    count_off("bbm gap", n);
    chk("bbm gap cycles", n, 2);
    chk("bbm drive_out", int'(drive_out), 2);
    wait_ready("bbm hold", n);
    chk("bbm hold remaining", n, 3);
    watch11 = 0;
    chk("bbm never 11", int'(saw11), 0);

    // same-value request
    request(2'b11);
    wait_ready("to 11", n);
    chk("pre-same drive_out", int'(drive_out), 3);
    request(2'b11);
    @(negedge clk);
    chk("same drive_out", int'(drive_out), 3);
    chk("same busy", int'(busy), 0);
    chk("same req_ready", int'(req_ready), 1);

    // abort mid-GAP toward 10
    watch10 = 1;
    request(2'b10);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_ready("abort gap", n);
    chk("abort gap hold cycles", n, 4);
    chk("abort gap drive_out", int'(drive_out), 0);
    repeat (3) @(negedge clk);
    watch10 = 0;
    chk("abort gap pending dropped", int'(saw10), 0);

    // abort together with a request in IDLE at 01
    request(2'b01);
    wait_ready("to 01 again", n);
    req_valid = 1'b1;
    req_data  = 2'b10;
    abort     = 1'b1;
    #1;
    chk("abort+req ready", int'(req_ready), 0);
    @(posedge clk);
    #1 abort = 1'b0;
    count_off("abort+req", n);
    chk("abort+req off cycles", n, 5);
    chk("abort+req drive_out", int'(drive_out), 2);
    req_valid = 1'b0;
    wait_ready("abort+req hold", n);

    // reset in the middle of a GAP drops the pending value
    request(2'b01);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst mid-gap drive_out", int'(drive_out), 0);
    chk("rst mid-gap busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("rst mid-gap stays off", int'(drive_out), 0);

    // abort held for three cycles from 11
    request(2'b11);
    wait_ready("to 11 again", n);
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1 abort = 1'b0;
    wait_ready("abort held", n);
    chk("abort held hold cycles", n, 4);

    // abort while already off and idle: no dwell
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort idle off busy", int'(busy), 0);
    chk("abort idle off drive_out", int'(drive_out), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
